// File: rtl/joy_db15_responder.sv
// joy_db15_responder: device-side DB15 joystick adapter model, two-player 24-bit parallel-in/serial-out chain
//   clk         system clock, asynchronous to the reader strobes
//   reset_n     asynchronous active-low reset, released synchronously inside
//   joy_clk     reader shift clock, shifts on its rising edge
//   joy_load    reader parallel load, active low, level-sensitive
//   joy_data    serial data, active-low button sense, registered
//   p1_buttons  player 1 buttons (R,L,D,U,A,B,C,X,Y,Z,S,M), 1 = pressed
//   p2_buttons  player 2 buttons, same order
//   bit_cnt     shifts since the last load, saturating at 2*NBTN
//   frame_done  one-clk pulse when the last bit of the frame has been shifted
//   link_active high while load pulses keep arriving within IDLE_TIMEOUT clks
module joy_db15_responder #(
  parameter int NBTN         = 12,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 4800000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            joy_clk,
  input  logic            joy_load,
  output logic            joy_data,
  input  logic [NBTN-1:0] p1_buttons,
  input  logic [NBTN-1:0] p2_buttons,
  output logic [5:0]      bit_cnt,
  output logic            frame_done,
  output logic            link_active
);
  localparam int FW = 2 * NBTN;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
  generate
    if (NBTN > 31 || SYNC_STAGES < 2) begin : g_bad_params
      $error("joy_db15_responder: NBTN must be <= 31 and SYNC_STAGES >= 2");
    end
  endgenerate
  logic [1:0]             rst_q;
  logic                   rst_n;
  logic [SYNC_STAGES-1:0] clk_sync, load_sync;
  logic                   clk_prev, load_prev;
  logic                   clk_s, load_s, rise, load_fall;
  logic [FW-1:0]          sr, sr_n;
  logic [5:0]             cnt_n;
  logic                   done_n;
  state_t                 state, state_n;
  logic [IW-1:0]          idle;
  // reset asserts immediately but releases two clks after reset_n rises
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_q <= 2'b00;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_n = rst_q[1];
  // presets model an idle reader: load inactive, shift clock high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_sync  <= '1;
      load_sync <= '1;
      clk_prev  <= 1'b1;
      load_prev <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], joy_clk};
      load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load};
      clk_prev  <= clk_s;
      load_prev <= load_s;
    end
  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign load_s    = load_sync[SYNC_STAGES-1];
  assign rise      = clk_s & ~clk_prev;
  assign load_fall = load_prev & ~load_s;
  // S_IDLE is only left through a load, so edges after reset never start a frame;
  // an edge on the cycle load releases is taken because load_s is already high
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = bit_cnt;
    done_n  = 1'b0;
    if (!load_s) begin
      state_n = S_LOAD;
      sr_n    = ~{p2_buttons, p1_buttons};
      cnt_n   = '0;
    end else if (rise && state != S_IDLE) begin
      sr_n = {1'b1, sr[FW-1:1]};
      if (state != S_DONE) begin
        cnt_n   = bit_cnt + 6'd1;
        done_n  = bit_cnt == 6'(FW - 1);
        state_n = done_n ? S_DONE : S_SHIFT;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      sr         <= '1;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      bit_cnt    <= cnt_n;
      frame_done <= done_n;
    end
  assign joy_data = sr[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idle        <= '0;
      link_active <= 1'b0;
    end else if (load_fall) begin
      idle        <= '0;
      link_active <= 1'b1;
    end else if (idle != IW'(IDLE_TIMEOUT - 1)) begin
      idle <= idle + 1'b1;
      if (idle == IW'(IDLE_TIMEOUT - 2)) link_active <= 1'b0;
    end
endmodule

// File: tb/tb_joy_db15_responder.sv
// tb_joy_db15_responder: randomized self-checking bench for joy_db15_responder against a frame-level model
module tb_joy_db15_responder;
  localparam int NBTN = 12;
  localparam int TO   = 100;
  localparam int HALF = 500;
  logic        clk = 0, reset_n = 0, joy_clk = 0, joy_load = 1;
  logic [11:0] p1 = 0, p2 = 0;
  logic        joy_data, frame_done, link_active;
  logic [5:0]  bit_cnt;
  int checks = 0, errors = 0, done_cnt = 0;
  always #10 clk = ~clk;
  always @(negedge clk) if (frame_done) done_cnt++;
  joy_db15_responder #(.NBTN(NBTN), .SYNC_STAGES(2), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .joy_clk(joy_clk), .joy_load(joy_load),
    .joy_data(joy_data), .p1_buttons(p1), .p2_buttons(p2), .bit_cnt(bit_cnt),
    .frame_done(frame_done), .link_active(link_active));
  // a button reads as 0 on the wire when pressed; past the frame only 1s remain
  function automatic logic exp_bit(input logic [11:0] a, input logic [11:0] b, input int k);
    if (k >= 24) return 1'b1;
    return k < 12 ? !a[k] : !b[k-12];
  endfunction
  task automatic edge_pulse();
    joy_clk = 1; #HALF;
    joy_clk = 0; #HALF;
  endtask
  task automatic load_pulse();
    joy_load = 0; #HALF;
    joy_load = 1; #HALF;
  endtask
  task automatic frame(input logic [11:0] a, input logic [11:0] b, input string nm);
    int d0;
    p1 = a; p2 = b;
    load_pulse();
    d0 = done_cnt;
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (joy_data !== exp_bit(a, b, i)) begin errors++; $display("FAIL %s bit %0d: got %b want %b", nm, i, joy_data, exp_bit(a, b, i)); end
      checks++;
      if (bit_cnt !== 6'(i)) begin errors++; $display("FAIL %s bit_cnt at %0d: got %0d want %0d", nm, i, bit_cnt, i); end
      checks++;
      if (done_cnt != d0) begin errors++; $display("FAIL %s early frame_done at %0d: got %0d want 0", nm, i, done_cnt - d0); end
      edge_pulse();
    end
    checks++;
    if (bit_cnt !== 6'd24) begin errors++; $display("FAIL %s end bit_cnt: got %0d want 24", nm, bit_cnt); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s frame_done pulses: got %0d want 1", nm, done_cnt - d0); end
    checks++;
    if (joy_data !== 1'b1) begin errors++; $display("FAIL %s end joy_data: got %b want 1", nm, joy_data); end
  endtask
  task automatic test_reset();
    repeat (40) begin
      joy_clk = 1'($urandom); joy_load = 1'($urandom); p1 = 12'($urandom);
      #20;
      checks++;
      if ({joy_data, bit_cnt, frame_done, link_active} !== {1'b1, 6'd0, 1'b0, 1'b0}) begin
        errors++; $display("FAIL reset: got data=%b cnt=%0d done=%b link=%b want 1 0 0 0", joy_data, bit_cnt, frame_done, link_active);
      end
    end
    joy_clk = 0; joy_load = 1; reset_n = 1;
    #200;
  endtask
  task automatic test_full_frame();
    int d0;
    frame(12'h001, 12'h800, "full_frame");
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) begin
      edge_pulse();
      checks++;
      if (joy_data !== 1'b1 || bit_cnt !== 6'd24) begin
        errors++; $display("FAIL overclock %0d: got data=%b cnt=%0d want 1 24", i, joy_data, bit_cnt);
      end
    end
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL overclock frame_done: got %0d extra want 0", done_cnt - d0); end
  endtask
  task automatic test_snapshot();
    logic [11:0] a, b;
    a = 12'h0F0; b = 12'($urandom);
    p1 = a; p2 = b;
    load_pulse();
    for (int i = 0; i < 24; i++) begin
      if (i == 3) begin p1 = 12'hFFF; p2 = ~b; end
      checks++;
      if (joy_data !== exp_bit(a, b, i)) begin errors++; $display("FAIL snapshot bit %0d: got %b want %b", i, joy_data, exp_bit(a, b, i)); end
      edge_pulse();
    end
  endtask
  task automatic test_load_dominance();
    p1 = 12'h002; p2 = 12'h000;
    joy_load = 0; #HALF;
    repeat (10) edge_pulse();
    checks++;
    if (bit_cnt !== 6'd0 || joy_data !== 1'b1) begin
      errors++; $display("FAIL load_dom hold: got cnt=%0d data=%b want 0 1", bit_cnt, joy_data);
    end
    joy_load = 1; #HALF;
    edge_pulse();
    checks++;
    if (bit_cnt !== 6'd1 || joy_data !== 1'b0) begin
      errors++; $display("FAIL load_dom release: got cnt=%0d data=%b want 1 0", bit_cnt, joy_data);
    end
  endtask
  task automatic test_random_frames();
    for (int n = 0; n < 4; n++) frame(12'($urandom), 12'($urandom), "random_frame");
  endtask
  task automatic test_idle();
    int n, k;
    repeat (150) #20;
    checks++;
    if (link_active !== 1'b0) begin errors++; $display("FAIL idle before load: got %b want 0", link_active); end
    joy_load = 0;
    n = 0;
    while (!link_active && n < 10) begin #20; n++; end
    checks++;
    if (link_active !== 1'b1) begin errors++; $display("FAIL idle link rise: got %b want 1", link_active); end
    joy_load = 1;
    k = 0;
    while (link_active && k < 200) begin k++; #20; end
    checks++;
    if (k != TO - 1) begin errors++; $display("FAIL idle timeout: got %0d cycles high want %0d", k, TO - 1); end
  endtask
  task automatic test_reset_mid_frame();
    p1 = 12'($urandom); p2 = 12'($urandom);
    load_pulse();
    repeat (5) edge_pulse();
    checks++;
    if (bit_cnt !== 6'd5) begin errors++; $display("FAIL midreset pre: got cnt=%0d want 5", bit_cnt); end
    reset_n = 0; #1;
    checks++;
    if (bit_cnt !== 6'd0 || joy_data !== 1'b1 || link_active !== 1'b0) begin
      errors++; $display("FAIL midreset: got cnt=%0d data=%b link=%b want 0 1 0", bit_cnt, joy_data, link_active);
    end
    #19; reset_n = 1; #200;
    repeat (3) edge_pulse();
    checks++;
    if (bit_cnt !== 6'd0 || joy_data !== 1'b1) begin
      errors++; $display("FAIL midreset no-load: got cnt=%0d data=%b want 0 1", bit_cnt, joy_data);
    end
    frame(12'($urandom), 12'($urandom), "after_reset");
  endtask
  initial begin
    #5;
    test_reset();
    test_full_frame();
    test_snapshot();
    test_load_dominance();
    test_random_frames();
    test_idle();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/joy_db15_responder.md
Name: joy_db15_responder

Overview:
- Device-side model of the DB15 serial joystick adapter: emulates the adapter's parallel-in/serial-out shift-register chain for two players.
- Driven by the console-side DB15 reader's JOY_CLK and JOY_LOAD strobes; returns button states on JOY_DATA.
- Used in sim benches and as a loopback target on a second board, so the host reader can be exercised without hardware.

Parameters:
- NBTN, 12, buttons per player (bit order R,L,D,U,A,B,C,X,Y,Z,S,M = indices 0..11).
- SYNC_STAGES, 2, synchronizer flops on joy_clk and joy_load (minimum 2).
- IDLE_TIMEOUT, 4800000, clk cycles with no load pulse before link_active drops (100 ms at 48 MHz).

Ports:
- clk  in  1  system clock, 40-50 MHz, asynchronous to the reader strobes.
- reset_n  in  1  asynchronous, active-low reset.
- joy_clk  in  1  shift clock from the reader; the shift happens on the rising edge.
- joy_load  in  1  parallel load, active low (level-sensitive).
- joy_data  out  1  serial data; active-low button sense; registered.
- p1_buttons  in  NBTN  player 1 buttons, 1 = pressed.
- p2_buttons  in  NBTN  player 2 buttons, 1 = pressed.
- bit_cnt  out  6  bits shifted since the last load; saturates at 2*NBTN.
- frame_done  out  1  one-clk pulse when the 2*NBTN-th shift completes.
- link_active  out  1  high while load pulses arrive within IDLE_TIMEOUT.

Behaviour:
- Reset (async assert, sync deassert via internal flop):
  - shift register all 1s; joy_data=1; bit_cnt=0; frame_done=0; link_active=0; idle counter=0.
  - Synchronizer flops preset to 1 (load inactive, clk high).
- Synchronization:
  - joy_clk and joy_load each pass through SYNC_STAGES flops.
  - One further flop on joy_clk provides rising-edge detect.
  - No logic uses the raw pins.
- Frame format: 2*NBTN = 24-bit register.
  - Bit k (0..11) = ~p1_buttons[k]; bit 12+k = ~p2_buttons[k].
  - joy_data always equals register bit 0, registered.
- States:
  - LOAD: synced load = 0.
    - Every clk, the register reloads from the current button inputs.
    - bit_cnt=0; joy_data = frame bit 0 by the following clk.
    - Shift-clock edges are ignored; load dominates a simultaneous edge.
  - SHIFT: synced load = 1, bit_cnt < 24.
    - On a detected joy_clk rising edge: register shifts right with serial-in = 1; bit_cnt increments.
    - New joy_data is valid 1 clk after the detected edge.
    - Pin-to-data latency is at most SYNC_STAGES+2 clk.
  - DONE: bit_cnt = 24.
    - Further edges keep shifting 1s, so joy_data=1; bit_cnt holds at 24.
    - frame_done pulses exactly once, on the cycle bit_cnt goes 23 to 24.
- Button changes during SHIFT/DONE have no effect until the next load (snapshot semantics).
- Load low → high transition: only the shift register's edge detector arms. A joy_clk rising edge coincident with load release (same synced cycle) counts as a shift.
- link_active:
  - Idle counter clears and link_active=1 on each synced load falling edge.
  - Otherwise the counter increments. At IDLE_TIMEOUT-1 it saturates and link_active=0.
- Reset asserted mid-frame: immediate return to reset values; the next frame starts only after a new load.
- bit_cnt width is fixed at 6; NBTN must be 31 or less (elaborate-time assert).

Test Plan:
- Reset: hold reset_n=0 with random strobes → joy_data=1, bit_cnt=0, frame_done=0, link_active=0 throughout.
- Full frame: p1=12'h001 (R), p2=12'h800 (M); load pulse, then 24 clocks at 1 MHz → sampled stream bit0=0, bits1..22=1, bit23=0; frame_done pulses once after clock 24; bit_cnt=24.
- Overclock: continue 8 extra joy_clk edges after the frame → joy_data=1, bit_cnt stays 24, no second frame_done.
- Snapshot: p1=12'h0F0 at load; change to 12'hFFF after 3 shifts → remaining bits still reflect 12'h0F0 (bits 4..7 = 0).
- Load dominance: assert joy_load=0 with joy_clk toggling for 10 edges, p1=12'h002 → bit_cnt=0, joy_data=1 (bit0). After release, the first edge gives joy_data=0 (bit1 = L).
- Idle/reset mid-frame: with IDLE_TIMEOUT=100, no load for 100 clk → link_active falls at cycle 100. Load pulse → link_active=1. Assert reset_n=0 after shift 5 → bit_cnt=0, joy_data=1 within the same cycle.
